// File: rtl/multi_spill_buffer_pkg.sv
// Sizing helpers shared by the multi-slot spill buffer and its protocol checker.
package multi_spill_buffer_pkg;

  // Width needed to index num_idx distinct values, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned num_idx);
    if (num_idx > 32'd1) begin
      return $clog2(num_idx);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/multi_spill_buffer_sva.sv
// Handshake stability checker: a held item on either side of the buffer must not
// change until it is accepted. Holds that were open when a flush occurred are not checked.
module multi_spill_buffer_sva #(
  parameter type T = logic
) (
  input logic clk_i,
  input logic rst_ni,
  input logic flush_i,
  input logic valid_i,
  input logic ready_o,
  input T     data_i,
  input logic valid_o,
  input logic ready_i,
  input T     data_o
);

  logic in_hold_r;
  logic out_hold_r;
  T     in_data_r;
  T     out_data_r;

  // Remember which side was stalled at the last edge; reset drops any pending hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_hold_r  <= 1'b0;
      out_hold_r <= 1'b0;
    end else begin
      in_hold_r  <= valid_i && !ready_o && !flush_i;
      out_hold_r <= valid_o && !ready_i && !flush_i;
    end
  end

  // Payload snapshot taken alongside the hold flags.
  always_ff @(posedge clk_i) begin
    in_data_r  <= data_i;
    out_data_r <= data_o;
  end

  // Compare the current cycle against the snapshot of a stalled transfer.
  always @(posedge clk_i) begin
    if (rst_ni && in_hold_r) begin
      a_in_stable : assert (valid_i && (data_i === in_data_r));
    end
    if (rst_ni && out_hold_r) begin
      a_out_stable : assert (valid_o && (data_o === out_data_r));
    end
  end

endmodule

// File: rtl/multi_spill_buffer.sv
// Multi-slot spill buffer: a Depth-entry FIFO whose ready_o/valid_o depend only on
// registered occupancy, breaking every combinational path through the handshake.
module multi_spill_buffer
  import multi_spill_buffer_pkg::*;
#(
  parameter type         T        = logic,
  parameter int unsigned Depth    = 32'd2,
  parameter bit          Bypass   = 1'b0,
  localparam int unsigned CntWidth = idx_width(Depth + 32'd1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  T                    data_i,
  output logic                valid_o,
  input  logic                ready_i,
  output T                    data_o,
  output logic [CntWidth-1:0] usage_o
);

  localparam int unsigned PtrWidth = idx_width(Depth);

  if (Depth < 32'd1) begin : g_depth_check
    $error("multi_spill_buffer: Depth must be at least 1");
  end

  if (Bypass) begin : g_bypass
    logic unused_bypass_s;

    assign valid_o         = valid_i;
    assign ready_o         = ready_i;
    assign data_o          = data_i;
    assign usage_o         = {CntWidth{1'b0}};
    assign unused_bypass_s = ^{clk_i, rst_ni, flush_i};
  end else begin : g_buffer
    logic [PtrWidth-1:0] wr_ptr_r;
    logic [PtrWidth-1:0] rd_ptr_r;
    logic [PtrWidth-1:0] wr_ptr_nxt_s;
    logic [PtrWidth-1:0] rd_ptr_nxt_s;
    logic [CntWidth-1:0] count_r;
    logic [CntWidth-1:0] count_nxt_s;
    logic                push_s;
    logic                pop_s;
    logic                ready_s;
    logic                valid_s;
    T                    mem_r [Depth];

    assign ready_s = (count_r != CntWidth'(Depth));
    assign valid_s = (count_r != {CntWidth{1'b0}});
    assign push_s  = valid_i && ready_s;
    assign pop_s   = valid_s && ready_i;

    // Pointers wrap explicitly at Depth-1 so non-power-of-two depths work.
    always_comb begin
      wr_ptr_nxt_s = wr_ptr_r;
      rd_ptr_nxt_s = rd_ptr_r;
      if (push_s) begin
        if (wr_ptr_r == PtrWidth'(Depth - 32'd1)) begin
          wr_ptr_nxt_s = {PtrWidth{1'b0}};
        end else begin
          wr_ptr_nxt_s = wr_ptr_r + PtrWidth'(1'b1);
        end
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        if (rd_ptr_r == PtrWidth'(Depth - 32'd1)) begin
          rd_ptr_nxt_s = {PtrWidth{1'b0}};
        end else begin
          rd_ptr_nxt_s = rd_ptr_r + PtrWidth'(1'b1);
        end
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
    end

    // Occupancy moves only on an unpaired push or pop.
    always_comb begin
      count_nxt_s = count_r;
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + CntWidth'(1'b1);
        2'b01:   count_nxt_s = count_r - CntWidth'(1'b1);
        default: count_nxt_s = count_r;
      endcase
    end

    // Control state; flush empties the buffer and swallows same-cycle traffic.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wr_ptr_r <= {PtrWidth{1'b0}};
        rd_ptr_r <= {PtrWidth{1'b0}};
        count_r  <= {CntWidth{1'b0}};
      end else if (flush_i) begin
        wr_ptr_r <= {PtrWidth{1'b0}};
        rd_ptr_r <= {PtrWidth{1'b0}};
        count_r  <= {CntWidth{1'b0}};
      end else begin
        wr_ptr_r <= wr_ptr_nxt_s;
        rd_ptr_r <= rd_ptr_nxt_s;
        count_r  <= count_nxt_s;
      end
    end

    // Payload storage is written only on an accepted push and is never cleared.
    always_ff @(posedge clk_i) begin
      if (push_s && !flush_i) begin
        mem_r[wr_ptr_r] <= data_i;
      end
    end

    assign ready_o = ready_s;
    assign valid_o = valid_s;
    assign data_o  = mem_r[rd_ptr_r];
    assign usage_o = count_r;

    multi_spill_buffer_sva #(
      .T(T)
    ) u_sva (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .flush_i(flush_i),
      .valid_i(valid_i),
      .ready_o(ready_s),
      .data_i (data_i),
      .valid_o(valid_s),
      .ready_i(ready_i),
      .data_o (mem_r[rd_ptr_r])
    );
  end

endmodule

// File: tb/tb_multi_spill_buffer.sv
// Directed and randomized bench for multi_spill_buffer with a queue scoreboard per instance.
module tb_multi_spill_buffer;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  // Depth 3 instance
  logic       f3, vi3, ri3, ro3, vo3;
  logic [7:0] di3, do3;
  logic [1:0] u3;
  // Depth 5 instance
  logic       f5, vi5, ri5, ro5, vo5;
  logic [7:0] di5, do5;
  logic [2:0] u5;
  // Bypass instance
  logic       fb, vib, rib, rob, vob;
  logic [7:0] dib, dob;
  logic [1:0] ub;

  int total  = 0;
  int passed = 0;
  logic [7:0] sb3[$];
  logic [7:0] sb5[$];

  multi_spill_buffer #(.T(logic [7:0]), .Depth(3), .Bypass(1'b0)) u_d3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(f3), .valid_i(vi3), .ready_o(ro3),
    .data_i(di3), .valid_o(vo3), .ready_i(ri3), .data_o(do3), .usage_o(u3));

  multi_spill_buffer #(.T(logic [7:0]), .Depth(5), .Bypass(1'b0)) u_d5 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(f5), .valid_i(vi5), .ready_o(ro5),
    .data_i(di5), .valid_o(vo5), .ready_i(ri5), .data_o(do5), .usage_o(u5));

  multi_spill_buffer #(.T(logic [7:0]), .Depth(3), .Bypass(1'b1)) u_byp (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(fb), .valid_i(vib), .ready_o(rob),
    .data_i(dib), .valid_o(vob), .ready_i(rib), .data_o(dob), .usage_o(ub));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Score the handshake of the current cycle, then advance to 1 ns after the edge.
  task automatic tick3();
    if (f3) begin
      sb3.delete();
    end else begin
      if (vo3 && ri3) begin
        if (sb3.size() == 0) check("d3_spurious_pop", 32'(vo3), 32'd0);
        else check("d3_data", 32'(do3), 32'(sb3.pop_front()));
      end
      if (vi3 && ro3) sb3.push_back(di3);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick5();
    if (f5) begin
      sb5.delete();
    end else begin
      if (vo5 && ri5) begin
        if (sb5.size() == 0) check("d5_spurious_pop", 32'(vo5), 32'd0);
        else check("d5_data", 32'(do5), 32'(sb5.pop_front()));
      end
      if (vi5 && ro5) sb5.push_back(di5);
    end
    @(posedge clk);
    #1;
    check("d5_usage", 32'(u5), 32'(sb5.size()));
  endtask

  initial begin
    logic acc;
    int   cyc;

    rst_n = 1'b1;
    {f3, vi3, ri3, di3} = '0;
    {f5, vi5, ri5, di5} = '0;
    {fb, vib, rib, dib} = '0;

    // Asynchronous reset takes effect without a clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid_o", 32'(vo3), 32'd0);
    check("rst_ready_o", 32'(ro3), 32'd1);
    check("rst_usage_o", 32'(u3), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fill to full with downstream stalled; fourth item is held off
    vi3 = 1'b1; di3 = 8'hA1;
    check("fill_ready_empty", 32'(ro3), 32'd1);
    tick3();
    check("fill_usage1", 32'(u3), 32'd1);
    check("fill_valid1", 32'(vo3), 32'd1);
    di3 = 8'hB2;
    tick3();
    check("fill_usage2", 32'(u3), 32'd2);
    di3 = 8'hC3;
    tick3();
    check("fill_usage3", 32'(u3), 32'd3);
    check("fill_ready_full", 32'(ro3), 32'd0);
    di3 = 8'h01;
    tick3();
    check("full_hold_usage", 32'(u3), 32'd3);
    check("full_hold_ready", 32'(ro3), 32'd0);

    // Release downstream and stream 0x01..0x10 behind the stored items
    ri3 = 1'b1;
    cyc = 0;
    while (vi3 && cyc < 40) begin
      acc = vi3 && ro3;
      tick3();
      cyc++;
      if (acc) begin
        if (di3 == 8'h10) vi3 = 1'b0;
        else di3 = di3 + 8'd1;
      end
    end
    check("stream_cycles", 32'(cyc), 32'd17);
    check("stream_usage", 32'(u3), 32'd2);
    repeat (2) tick3();
    check("drain_usage", 32'(u3), 32'd0);
    check("drain_valid", 32'(vo3), 32'd0);
    check("drain_sb_empty", 32'(sb3.size()), 32'd0);

    // Single push into empty appears exactly one cycle later
    vi3 = 1'b1; di3 = 8'h55;
    check("single_valid_before", 32'(vo3), 32'd0);
    tick3();
    vi3 = 1'b0;
    check("single_valid_after", 32'(vo3), 32'd1);
    check("single_data", 32'(do3), 32'h55);
    tick3();
    check("single_usage_end", 32'(u3), 32'd0);

    // Flush with concurrent push and pop discards everything
    ri3 = 1'b0; vi3 = 1'b1; di3 = 8'h11;
    tick3();
    di3 = 8'h22;
    tick3();
    check("preflush_usage", 32'(u3), 32'd2);
    f3 = 1'b1; vi3 = 1'b1; di3 = 8'h33; ri3 = 1'b1;
    tick3();
    f3 = 1'b0; vi3 = 1'b0; ri3 = 1'b0;
    check("flush_usage", 32'(u3), 32'd0);
    check("flush_valid", 32'(vo3), 32'd0);
    check("flush_ready", 32'(ro3), 32'd1);
    vi3 = 1'b1; di3 = 8'h77;
    tick3();
    vi3 = 1'b0;
    check("postflush_data", 32'(do3), 32'h77);
    ri3 = 1'b1;
    tick3();
    ri3 = 1'b0;
    check("postflush_usage", 32'(u3), 32'd0);

    // Reset mid-operation with three stored items
    vi3 = 1'b1; di3 = 8'h91;
    tick3();
    di3 = 8'h92;
    tick3();
    di3 = 8'h93;
    tick3();
    vi3 = 1'b0;
    check("prerst_usage", 32'(u3), 32'd3);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(vo3), 32'd0);
    check("midrst_ready", 32'(ro3), 32'd1);
    check("midrst_usage", 32'(u3), 32'd0);
    sb3.delete();
    sb5.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    vi3 = 1'b1; di3 = 8'h5A;
    tick3();
    vi3 = 1'b0;
    check("postrst_valid", 32'(vo3), 32'd1);
    check("postrst_data", 32'(do3), 32'h5A);
    check("postrst_usage", 32'(u3), 32'd1);
    ri3 = 1'b1;
    tick3();
    check("postrst_drain", 32'(u3), 32'd0);

    // Bypass instance is transparent within the same cycle
    vib = 1'b1; rib = 1'b0; dib = 8'h3C; fb = 1'b1;
    #1;
    check("byp_valid", 32'(vob), 32'd1);
    check("byp_ready", 32'(rob), 32'd0);
    check("byp_data", 32'(dob), 32'h3C);
    check("byp_usage", 32'(ub), 32'd0);
    vib = 1'b0; rib = 1'b1; dib = 8'hC5;
    #1;
    check("byp_data2", 32'(dob), 32'hC5);
    check("byp_ready2", 32'(rob), 32'd1);
    check("byp_valid2", 32'(vob), 32'd0);
    fb = 1'b0;
    @(posedge clk);
    #1;

    // Depth 5 randomized traffic against the scoreboard
    for (int c = 0; c < 10000; c++) begin
      if (!vi5) begin
        vi5 = ($urandom_range(3, 0) != 0);
        di5 = 8'($urandom_range(255, 0));
      end
      ri5 = ($urandom_range(99, 0) < ((c % 2000) < 1000 ? 30 : 80));
      f5  = ($urandom_range(499, 0) == 0);
      if ((c % 250) == 3) begin
        ri5 = ~ri5; vi5 = ~vi5; f5 = ~f5;
        #1;
        check("d5_ready_comb", 32'(ro5), 32'(sb5.size() != 5));
        check("d5_valid_comb", 32'(vo5), 32'(sb5.size() != 0));
        ri5 = ~ri5; vi5 = ~vi5; f5 = ~f5;
        #1;
      end
      acc = vi5 && ro5;
      tick5();
      if (acc) vi5 = 1'b0;
    end
    vi5 = 1'b0; f5 = 1'b0; ri5 = 1'b1;
    repeat (8) tick5();
    check("d5_final_sb_empty", 32'(sb5.size()), 32'd0);
    check("d5_final_valid", 32'(vo5), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
